partial_sum_accumulator: RTL
============================

// Module: partial_sum_accumulator
// PURPOSE
//  Final reduction stage of the 32x32 multiplier datapath. Takes the 16
//  pairwise partial-product sums from the partial-product stage in one
//  transfer and accumulates them LANES terms per cycle into the 64-bit
//  product. Sits between the partial-product stage and the product consumer.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  W          64  width of each partial sum, of the accumulator and of the result
//  NUM_TERMS  16  partial sums per operation
//  LANES      4   terms added per accumulate cycle; must divide NUM_TERMS
// PORTS
//  clk        in   1             sole clock, rising edge
//  reset      in   1             synchronous, active-high
//  in_valid   in   1             in_terms holds a complete operand set
//  in_ready   out  1             block can accept a set (IDLE only)
//  in_terms   in   NUM_TERMS*W   term k at bits [k*W +: W]
//  out_valid  out  1             out_sum/out_ovf valid; held until accepted
//  out_ready  in   1             consumer accepts the result
//  out_sum    out  W             sum of all terms, mod 2^W
//  out_ovf    out  1             sticky: a carry out of bit W-1 occurred
// BEHAVIOUR
//  Clocking: one clock, clk. reset is synchronous and active-high.
//  Reset: state=IDLE, acc=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0,
//   term register=0. in_ready=1 in the first cycle after reset deasserts.
//  FSM states:
//   IDLE  - in_ready=1. On in_valid: latch all terms, acc=0, ovf=0, cnt=0,
//           go to ACCUM.
//   ACCUM - each edge: acc += terms[cnt*LANES .. cnt*LANES+LANES-1], cnt++.
//           On the edge where cnt==NUM_TERMS/LANES-1: load out_sum and
//           out_ovf, go to DONE.
//   DONE  - out_valid=1. On out_ready: go to IDLE, out_valid=0.
//  Latency: transfer accepted at edge T; out_valid=1 after edge
//   T+NUM_TERMS/LANES (T+4 with the defaults).
//  Throughput: one operation per NUM_TERMS/LANES+2 cycles when out_ready=1.
//   in_ready=0 in ACCUM and DONE; there is no overlap.
//  Arithmetic: the LANES terms and acc are summed with full carry. acc keeps
//   the low W bits. ovf is ORed with (any bits above W are nonzero) on every
//   accumulate cycle.
//  Backpressure: in DONE, out_sum and out_ovf stay stable while
//   out_ready=0, for any number of cycles.
//  in_terms is sampled only on the accept edge. Later changes to in_terms
//   have no effect on the operation in progress.
//  Reset mid-operation (ACCUM or DONE): the operation is discarded; all
//   registers return to reset values on that edge; no out_valid pulse.
//  reset has priority over in_valid and out_ready on the same edge.
//  out_valid never rises without a preceding accepted input.
// TESTING
//  1 All 16 terms = 64'h1, out_ready=1 -> out_sum=64'h10, out_ovf=0,
//    out_valid exactly 4 cycles after accept, in_ready low until return.
//  2 Terms from the partial-product stage for A=B=32'hFFFFFFFF ->
//    out_sum=64'hFFFFFFFE00000001, out_ovf=0.
//  3 All 16 terms = 64'hFFFFFFFFFFFFFFFF -> out_sum=64'hFFFFFFFFFFFFFFF0,
//    out_ovf=1.
//  4 out_ready=0 for 10 cycles in DONE -> out_valid and out_sum stable,
//    in_ready=0 throughout, in_valid ignored; accept on the 11th cycle.
//  5 reset pulsed on the 2nd ACCUM cycle -> next cycle IDLE, out_valid=0,
//    out_sum=0; a new operation then gives the correct result.
//  6 Back-to-back: 3 operations with in_valid held high and out_ready=1 ->
//    3 correct results, each 6 cycles apart.

Source files
------------

// File: rtl/partial_sum_accumulator.sv
// Final reduction stage of the 32x32 multiplier: latches NUM_TERMS partial sums
// and folds them LANES per cycle into a W-bit result with a sticky carry-out flag.
module partial_sum_accumulator #(
  parameter int W         = 64,
  parameter int NUM_TERMS = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_TERMS*W-1:0] in_terms,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_sum,
  output logic                   out_ovf
);

  localparam int STEPS = NUM_TERMS / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  // Headroom so LANES terms plus the accumulator can never wrap the adder tree.
  localparam int XW    = $clog2(LANES + 1);
  localparam int SW    = W + XW;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 r_state;
  logic [NUM_TERMS*W-1:0] r_terms;
  logic [W-1:0]           r_acc;
  logic                   r_ovf;
  logic [CW-1:0]          r_cnt;
  logic [W-1:0]           r_sum;
  logic                   r_out_ovf;
  logic                   r_out_valid;
  logic                   r_in_ready;

  logic [W-1:0]  w_lane [LANES];
  logic [SW-1:0] w_total;
  logic          w_ovf;
  logic          w_last;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = r_terms[(int'(r_cnt) * LANES + gi) * W +: W];
    end
  endgenerate

  always_comb begin
    w_total = SW'(r_acc);
    for (int l = 0; l < LANES; l++) begin
      w_total = w_total + SW'(w_lane[l]);
    end
  end

  assign w_ovf  = r_ovf | (|w_total[SW-1:W]);
  assign w_last = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_terms     <= '0;
      r_acc       <= '0;
      r_ovf       <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_terms    <= in_terms;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ACCUM;
          end
        end
        ACCUM: begin
          r_acc <= w_total[W-1:0];
          r_ovf <= w_ovf;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum       <= w_total[W-1:0];
            r_out_ovf   <= w_ovf;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_ovf   = r_out_ovf;

endmodule
